// File: rtl/alu_operand_stage.sv
// Two-entry (main + skid) operand register between decode and the ALU.
// Define ALU_OPERAND_FWD_EN to forward writeback data into incoming and held operands.
module alu_operand_stage #(
    parameter int N  = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    input  logic [4:0]    in_alufn,
    input  logic [AW-1:0] in_rs,
    input  logic [AW-1:0] in_rt,
    input  logic [AW-1:0] in_wa,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_a,
    output logic [N-1:0]  out_b,
    output logic [4:0]    out_alufn,
    output logic [AW-1:0] out_wa,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_addr,
    input  logic [N-1:0]  wb_data
);
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_load_main_in;
    logic          w_load_main_skid;
    logic          w_load_skid;

    logic [N-1:0]  r_main_a, r_main_b, r_skid_a, r_skid_b;
    logic [4:0]    r_main_alufn, r_skid_alufn;
    logic [AW-1:0] r_main_wa, r_skid_wa;

    // Operand values after any writeback forwarding has been applied.
    logic [N-1:0]  w_in_a, w_in_b, w_main_a, w_main_b, w_skid_a, w_skid_b;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_EMPTY;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_in_fire) begin
                    w_load_main_in = 1'b1;
                    w_state_nxt    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_fire) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = S_FULL;
                end else if (w_out_fire) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_out_fire) begin
                    w_load_main_skid = 1'b1;
                    w_state_nxt      = S_BUSY;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // in_ready depends only on state and reset so upstream never sees a comb loop.
    always_comb begin
        in_ready  = ~reset & (r_state != S_FULL);
        out_valid = (r_state != S_EMPTY);
    end

`ifdef ALU_OPERAND_FWD_EN
    logic [AW-1:0] r_main_rs, r_main_rt, r_skid_rs, r_skid_rt;

    function automatic logic [N-1:0] f_fwd(input logic [N-1:0] v, input logic [AW-1:0] rn,
                                           input logic wv, input logic [AW-1:0] wa,
                                           input logic [N-1:0] wd);
        return (wv && (wa != '0) && (wa == rn)) ? wd : v;
    endfunction

    assign w_in_a   = f_fwd(in_a,     in_rs,     wb_valid, wb_addr, wb_data);
    assign w_in_b   = f_fwd(in_b,     in_rt,     wb_valid, wb_addr, wb_data);
    assign w_main_a = f_fwd(r_main_a, r_main_rs, wb_valid, wb_addr, wb_data);
    assign w_main_b = f_fwd(r_main_b, r_main_rt, wb_valid, wb_addr, wb_data);
    assign w_skid_a = f_fwd(r_skid_a, r_skid_rs, wb_valid, wb_addr, wb_data);
    assign w_skid_b = f_fwd(r_skid_b, r_skid_rt, wb_valid, wb_addr, wb_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_rs <= '0;
            r_main_rt <= '0;
            r_skid_rs <= '0;
            r_skid_rt <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_rs <= in_rs;
                r_main_rt <= in_rt;
            end else if (w_load_main_skid) begin
                r_main_rs <= r_skid_rs;
                r_main_rt <= r_skid_rt;
            end
            if (w_load_skid) begin
                r_skid_rs <= in_rs;
                r_skid_rt <= in_rt;
            end
        end
    end
`else
    logic w_unused_fwd;

    assign w_unused_fwd = ^{wb_valid, wb_addr, wb_data, in_rs, in_rt};
    assign w_in_a   = in_a;
    assign w_in_b   = in_b;
    assign w_main_a = r_main_a;
    assign w_main_b = r_main_b;
    assign w_skid_a = r_skid_a;
    assign w_skid_b = r_skid_b;
`endif

    // Held entries take their snooped value every cycle they are not reloaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_a     <= '0;
            r_main_b     <= '0;
            r_main_alufn <= '0;
            r_main_wa    <= '0;
            r_skid_a     <= '0;
            r_skid_b     <= '0;
            r_skid_alufn <= '0;
            r_skid_wa    <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_a     <= w_in_a;
                r_main_b     <= w_in_b;
                r_main_alufn <= in_alufn;
                r_main_wa    <= in_wa;
            end else if (w_load_main_skid) begin
                r_main_a     <= w_skid_a;
                r_main_b     <= w_skid_b;
                r_main_alufn <= r_skid_alufn;
                r_main_wa    <= r_skid_wa;
            end else begin
                r_main_a     <= w_main_a;
                r_main_b     <= w_main_b;
            end
            if (w_load_skid) begin
                r_skid_a     <= w_in_a;
                r_skid_b     <= w_in_b;
                r_skid_alufn <= in_alufn;
                r_skid_wa    <= in_wa;
            end else begin
                r_skid_a     <= w_skid_a;
                r_skid_b     <= w_skid_b;
            end
        end
    end

    assign out_a     = r_main_a;
    assign out_b     = r_main_b;
    assign out_alufn = r_main_alufn;
    assign out_wa    = r_main_wa;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomized self-checking bench for alu_operand_stage against a queue-based FIFO model.
// Forwarding checks are active when ALU_OPERAND_FWD_EN is defined.
module tb_alu_operand_stage;
    localparam int N  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_a = '0, in_b = '0;
    logic [4:0]    in_alufn = '0;
    logic [AW-1:0] in_rs = '0, in_rt = '0, in_wa = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  out_a, out_b;
    logic [4:0]    out_alufn;
    logic [AW-1:0] out_wa;
    logic          wb_valid = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic [N-1:0]  wb_data = '0;

    alu_operand_stage #(.N(N), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_alufn(in_alufn),
        .in_rs(in_rs), .in_rt(in_rt), .in_wa(in_wa),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_alufn(out_alufn), .out_wa(out_wa),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  a;
        logic [N-1:0]  b;
        logic [4:0]    fn;
        logic [AW-1:0] wa;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
    } op_t;

    op_t q[$];
    bit  rst_fresh = 1'b0;
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge in the reference: ops leave in order, survivors and the
    // newcomer see the writeback, capacity is two.
    task automatic model_edge();
        bit  acc, dep;
        op_t op;
        if (reset) begin
            q.delete();
            rst_fresh = 1'b1;
            return;
        end
        acc = in_valid && (q.size() < 2);
        dep = (q.size() > 0) && out_ready;
        if (dep) void'(q.pop_front());
        op = '{a: in_a, b: in_b, fn: in_alufn, wa: in_wa, rs: in_rs, rt: in_rt};
`ifdef ALU_OPERAND_FWD_EN
        if (wb_valid && wb_addr != 0) begin
            foreach (q[i]) begin
                if (q[i].rs == wb_addr) q[i].a = wb_data;
                if (q[i].rt == wb_addr) q[i].b = wb_data;
            end
            if (op.rs == wb_addr) op.a = wb_data;
            if (op.rt == wb_addr) op.b = wb_data;
        end
`endif
        if (acc) begin
            q.push_back(op);
            rst_fresh = 1'b0;
        end
    endtask

    task automatic compare_outputs();
        check("in_ready", N'(in_ready), N'(!reset && q.size() < 2));
        check("out_valid", N'(out_valid), N'(q.size() > 0));
        if (q.size() > 0) begin
            check("out_a", out_a, q[0].a);
            check("out_b", out_b, q[0].b);
            check("out_alufn", N'(out_alufn), N'(q[0].fn));
            check("out_wa", N'(out_wa), N'(q[0].wa));
        end else if (rst_fresh) begin
            check("rst_out_a", out_a, '0);
            check("rst_out_b", out_b, '0);
            check("rst_out_alufn", N'(out_alufn), '0);
            check("rst_out_wa", N'(out_wa), '0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [4:0] fn, input logic [AW-1:0] rs,
                         input logic [AW-1:0] rt, input logic [AW-1:0] wa);
        in_valid = v; in_a = a; in_b = b; in_alufn = fn;
        in_rs = rs; in_rt = rt; in_wa = wa;
    endtask

    initial begin
        // reset for two cycles
        reset = 1'b1;
        tick();
        tick();
        check("reset_in_ready", N'(in_ready), '0);
        check("reset_out_a", out_a, '0);
        reset = 1'b0;
        #1;
        check("post_reset_in_ready", N'(in_ready), N'(1));

        // single op, one-cycle latency
        out_ready = 1'b1;
        drive(1'b1, 32'd5, 32'd3, 5'b10001, '0, '0, 5'd9);
        tick();
        check("single_a", out_a, 32'd5);
        check("single_fn", N'(out_alufn), N'(5'b10001));
        drive(1'b0, '0, '0, '0, '0, '0, '0);
        tick();

        // stall: X then Y fill the stage, a third offer is refused
        out_ready = 1'b0;
        drive(1'b1, 32'h1111, 32'h2222, 5'b00011, '0, '0, 5'd1);
        tick();
        drive(1'b1, 32'h3333, 32'h4444, 5'b01100, '0, '0, 5'd2);
        tick();
        drive(1'b1, 32'h5555, 32'h6666, 5'b00000, '0, '0, 5'd3);
        tick();
        check("full_in_ready", N'(in_ready), '0);
        check("full_hold_a", out_a, 32'h1111);
        drive(1'b0, '0, '0, '0, '0, '0, '0);
        out_ready = 1'b1;
        tick();
        check("drain_y_a", out_a, 32'h3333);
        tick();
        check("drain_empty", N'(out_valid), '0);

        // reset while FULL discards both entries
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 32'hB, 5'd1, '0, '0, 5'd4);
        tick();
        drive(1'b1, 32'hC, 32'hD, 5'd2, '0, '0, 5'd5);
        tick();
        reset = 1'b1;
        drive(1'b0, '0, '0, '0, '0, '0, '0);
        tick();
        reset = 1'b0;
        #1;
        check("rst_full_valid", N'(out_valid), '0);
        check("rst_full_ready", N'(in_ready), N'(1));
        out_ready = 1'b1;
        drive(1'b1, 32'hE, 32'hF, 5'd3, '0, '0, 5'd6);
        tick();
        check("z_alone_a", out_a, 32'hE);
        drive(1'b0, '0, '0, '0, '0, '0, '0);
        tick();
        check("z_alone_gone", N'(out_valid), '0);

`ifdef ALU_OPERAND_FWD_EN
        // forward into an incoming operand, ignore writes to r0
        drive(1'b1, 32'h1, 32'h2, 5'd0, 5'd4, '0, 5'd1);
        wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h99;
        tick();
        check("fwd_in_a", out_a, 32'h99);
        drive(1'b1, 32'h12, 32'h2, 5'd0, '0, '0, 5'd1);
        wb_addr = 5'd0; wb_data = 32'h77;
        tick();
        check("fwd_r0_a", out_a, 32'h12);
        wb_valid = 1'b0;
        drive(1'b0, '0, '0, '0, '0, '0, '0);
        tick();

        // forward into an op waiting in the skid entry
        out_ready = 1'b0;
        drive(1'b1, 32'h10, 32'h20, 5'd1, '0, '0, 5'd1);
        tick();
        drive(1'b1, 32'h30, 32'h1, 5'd2, '0, 5'd7, 5'd2);
        tick();
        drive(1'b0, '0, '0, '0, '0, '0, '0);
        wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'hAB;
        tick();
        wb_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("fwd_skid_b", out_b, 32'hAB);
        tick();
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 63) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom),
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom));
            wb_valid = $urandom_range(0, 1) != 0;
            wb_addr  = AW'($urandom_range(0, 7));
            wb_data  = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
